// File: rtl/ray_core_scheduler_if.sv
// Ray-core and traversal-output bundle for ray_core_scheduler.
// master = scheduler side, slave = cores plus downstream consumer.
interface ray_core_scheduler_if #(
    parameter int NUM_CORES = 4,
    parameter int DW        = 32
);
    logic [NUM_CORES-1:0]    core_en;
    logic [1:0]              core_op_code;
    logic [NUM_CORES-1:0]    core_valid;
    logic [NUM_CORES*DW-1:0] core_dir_x;
    logic [NUM_CORES*DW-1:0] core_dir_y;
    logic [NUM_CORES*DW-1:0] core_dir_z;
    logic [NUM_CORES*DW-1:0] core_index;
    logic [NUM_CORES-1:0]    core_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [DW-1:0]           out_dir_x;
    logic [DW-1:0]           out_dir_y;
    logic [DW-1:0]           out_dir_z;
    logic [DW-1:0]           out_index;

    modport master (
        output core_en, core_op_code, core_ready,
        output out_valid, out_dir_x, out_dir_y, out_dir_z, out_index,
        input  core_valid, core_dir_x, core_dir_y, core_dir_z, core_index,
        input  out_ready
    );

    modport slave (
        input  core_en, core_op_code, core_ready,
        input  out_valid, out_dir_x, out_dir_y, out_dir_z, out_index,
        output core_valid, core_dir_x, core_dir_y, core_dir_z, core_index,
        output out_ready
    );
endinterface

// File: rtl/ray_core_scheduler.sv
// Frame controller plus round-robin arbiter merging NUM_CORES ray generators
// into one registered output stream; counts rays and pulses frame completion.
module ray_core_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int DW        = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [12:0]          image_width,
    input  logic [12:0]          image_height,
    ray_core_scheduler_if.master bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic [DW-1:0]        rays_issued
);
    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t               r_state, w_next;
    logic [25:0]          r_total, r_granted;
    logic [PW-1:0]        r_rr;
    logic                 r_out_valid;
    logic [DW-1:0]        r_out_dir_x, r_out_dir_y, r_out_dir_z, r_out_index;
    logic [DW-1:0]        r_rays;

    logic [25:0]          w_total;
    logic                 w_slot_free, w_xfer, w_found, w_grant, w_start_ok;
    logic [PW-1:0]        w_sel;
    logic [NUM_CORES-1:0] w_ready, w_core_en;
    logic [DW-1:0]        w_dx, w_dy, w_dz, w_idx;
    logic                 w_busy, w_done;

    assign w_total     = 26'(image_width) * 26'(image_height);
    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_xfer      = r_out_valid && bus.out_ready;
    assign w_start_ok  = (r_state == S_IDLE) && start;
    assign w_grant     = (r_state == S_RUN) && w_slot_free && (r_granted < r_total) && w_found;

    // Round-robin: first valid core at or above the pointer, then wrap below it.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!w_found && bus.core_valid[i] && i >= int'(r_rr)) begin
                w_found = 1'b1;
                w_sel   = PW'(i);
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!w_found && bus.core_valid[i] && i < int'(r_rr)) begin
                w_found = 1'b1;
                w_sel   = PW'(i);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        w_dx    = '0;
        w_dy    = '0;
        w_dz    = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_ready[i] = w_grant && (w_sel == PW'(i));
            if (w_sel == PW'(i)) begin
                w_dx  = bus.core_dir_x[i*DW +: DW];
                w_dy  = bus.core_dir_y[i*DW +: DW];
                w_dz  = bus.core_dir_z[i*DW +: DW];
                w_idx = bus.core_index[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_core_en = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = (w_total == 26'd0) ? S_DONE : S_LAUNCH;
            end
            S_LAUNCH: begin
                w_busy    = 1'b1;
                w_core_en = '1;
                w_next    = S_RUN;
            end
            S_RUN: begin
                w_busy    = 1'b1;
                w_core_en = '1;
                if ((w_grant && (r_granted + 26'd1 == r_total)) || (r_granted >= r_total))
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (!r_out_valid) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_total     <= '0;
            r_granted   <= '0;
            r_rr        <= '0;
            r_out_valid <= 1'b0;
            r_out_dir_x <= '0;
            r_out_dir_y <= '0;
            r_out_dir_z <= '0;
            r_out_index <= '0;
            r_rays      <= '0;
        end else begin
            if (w_start_ok) begin
                r_total   <= w_total;
                r_granted <= '0;
            end
            // A grant refills the slot in the same cycle it drains: no bubble.
            if (w_grant) begin
                r_out_valid <= 1'b1;
                r_out_dir_x <= w_dx;
                r_out_dir_y <= w_dy;
                r_out_dir_z <= w_dz;
                r_out_index <= w_idx;
                r_granted   <= r_granted + 26'd1;
                r_rr        <= (int'(w_sel) == NUM_CORES - 1) ? '0 : w_sel + 1'b1;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end
            if (w_start_ok)  r_rays <= '0;
            else if (w_xfer) r_rays <= r_rays + 1'b1;
        end
    end

    assign bus.core_en      = w_core_en;
    assign bus.core_op_code = 2'(NUM_CORES - 1);
    assign bus.core_ready   = w_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_dir_x    = r_out_dir_x;
    assign bus.out_dir_y    = r_out_dir_y;
    assign bus.out_dir_z    = r_out_dir_z;
    assign bus.out_index    = r_out_index;
    assign busy             = w_busy;
    assign frame_done       = w_done;
    assign rays_issued      = r_rays;
endmodule

// File: tb/tb_ray_core_scheduler.sv
// Directed bench for ray_core_scheduler: core i presents index i*100+n for its n-th ray.
module tb_ray_core_scheduler;
    localparam int NC = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [12:0]   iw, ih;
    logic          busy, frame_done;
    logic [DW-1:0] rays_issued;

    ray_core_scheduler_if #(.NUM_CORES(NC), .DW(DW)) bus();

    ray_core_scheduler #(.NUM_CORES(NC), .DW(DW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .image_width  (iw),
        .image_height (ih),
        .bus          (bus),
        .busy         (busy),
        .frame_done   (frame_done),
        .rays_issued  (rays_issued)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cnt[NC];
    int gr[$];
    logic [DW-1:0] got[$];
    int cyc = 0, fd_cnt, fd_cyc, last_x, vrun, maxrun, multi;
    int exp_b[8] = '{0, 100, 200, 300, 1, 101, 201, 301};
    int exp_f[9] = '{300, 0, 100, 200, 301, 1, 101, 201, 302};
    logic [DW-1:0] hold_idx;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive_cores();
        for (int i = 0; i < NC; i++) begin
            bus.core_dir_x[i*DW +: DW] = 32'h1000 + 32'(i);
            bus.core_dir_y[i*DW +: DW] = 32'h2000 + 32'(i);
            bus.core_dir_z[i*DW +: DW] = 32'h3000 + 32'(i);
            bus.core_index[i*DW +: DW] = 32'(i * 100 + cnt[i]);
        end
    endtask

    task automatic clear_logs();
        got.delete();
        gr.delete();
        fd_cnt = 0; fd_cyc = 0; last_x = 0; vrun = 0; maxrun = 0; multi = 0;
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        drive_cores();
    endtask

    // Log pre-edge activity, advance one clock, then let cores present their next ray.
    task automatic tick();
        logic [NC-1:0] cons;
        #1;
        cons = bus.core_valid & bus.core_ready;
        if (bus.out_valid && bus.out_ready) begin
            got.push_back(bus.out_index);
            last_x = cyc;
        end
        for (int i = 0; i < NC; i++) if (bus.core_ready[i]) gr.push_back(i);
        if ($countones(bus.core_ready) > 1) multi++;
        if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
        if (bus.out_valid) begin vrun++; if (vrun > maxrun) maxrun = vrun; end
        else vrun = 0;
        @(posedge clk); #1;
        cyc++;
        for (int i = 0; i < NC; i++) if (cons[i]) cnt[i]++;
        drive_cores();
        #1;
    endtask

    task automatic do_start(input logic [12:0] w, input logic [12:0] h);
        iw = w; ih = h; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n, f0;
        n = 0; f0 = fd_cnt;
        while (fd_cnt == f0 && n < maxc) begin tick(); n++; end
        chk("done_timeout", 64'(fd_cnt != f0), 64'd1);
        tick();
    endtask

    function automatic logic [63:0] pack_gr();
        logic [63:0] v;
        v = '0;
        foreach (gr[k]) v = (v << 4) | 64'(gr[k]);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; iw = '0; ih = '0;
        bus.core_valid = '0; bus.out_ready = 1'b1;
        clear_logs();
        #1 reset_n = 1'b1;
        tick(); tick();
        reset_n = 1'b0;
        tick();

        // reset state
        chk("rst_core_en", bus.core_en, 0);
        chk("rst_core_ready", bus.core_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_index", bus.out_index, 0);
        chk("rst_out_dir_x", bus.out_dir_x, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_rays", rays_issued, 0);
        chk("op_code", bus.core_op_code, 3);

        // reset mid-RUN aborts, then a fresh 2x2 frame runs normally
        clear_logs();
        bus.core_valid = 4'hF;
        do_start(4, 4);
        repeat (4) tick();
        chk("A_pre_rays", rays_issued, 2);
        chk("A_pre_ov", bus.out_valid, 1);
        #2 reset_n = 1'b1;
        #1;
        chk("A_rst_core_en", bus.core_en, 0);
        chk("A_rst_ov", bus.out_valid, 0);
        chk("A_rst_rays", rays_issued, 0);
        chk("A_rst_busy", busy, 0);
        chk("A_rst_ready", bus.core_ready, 0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("A_idle_busy", busy, 0);
        chk("A_idle_ready", bus.core_ready, 0);
        clear_logs();
        do_start(2, 2);
        wait_done(40);
        chk("A_new_rays", rays_issued, 4);
        chk("A_new_grants", pack_gr(), 64'h0123);

        // 4x2, all valid, no backpressure
        clear_logs();
        bus.core_valid = 4'hF; bus.out_ready = 1'b1;
        do_start(4, 2);
        chk("B_launch_busy", busy, 1);
        chk("B_launch_en", bus.core_en, 4'hF);
        chk("B_launch_ready", bus.core_ready, 0);
        wait_done(40);
        chk("B_grants", pack_gr(), 64'h01230123);
        chk("B_nxfer", got.size(), 8);
        for (int k = 0; k < 8; k++)
            chk("B_idx", (k < got.size()) ? got[k] : '1, 64'(exp_b[k]));
        chk("B_vrun", maxrun, 8);
        chk("B_rays", rays_issued, 8);
        chk("B_fd_cnt", fd_cnt, 1);
        chk("B_fd_gap", 64'(fd_cyc - last_x), 2);
        chk("B_onehot", multi, 0);
        chk("B_end_en", bus.core_en, 0);
        chk("B_end_busy", busy, 0);

        // round-robin skip and wrap
        clear_logs();
        bus.core_valid = 4'b0010;
        do_start(1, 2);
        wait_done(40);
        chk("C_pre_grants", pack_gr(), 64'h11);
        clear_logs();
        bus.core_valid = 4'b1010;
        do_start(3, 1);
        tick();
        tick(); tick();
        chk("C_first_two", pack_gr(), 64'h31);
        bus.core_valid = 4'b0000;
        tick(); tick(); tick();
        chk("C_gap_none", gr.size(), 2);
        bus.core_valid = 4'b1110;
        wait_done(20);
        chk("C_grants", pack_gr(), 64'h312);
        chk("C_rays", rays_issued, 3);

        // backpressure hold then same-cycle accept + regrant
        clear_logs();
        bus.core_valid = 4'hF; bus.out_ready = 1'b0;
        do_start(2, 2);
        tick();
        tick();
        hold_idx = bus.out_index;
        chk("D_first_idx", hold_idx, 300);
        for (int k = 0; k < 5; k++) begin
            chk("D_hold_ready", bus.core_ready, 0);
            chk("D_hold_idx", bus.out_index, hold_idx);
            chk("D_hold_dx", bus.out_dir_x, 32'h1003);
            chk("D_hold_ov", bus.out_valid, 1);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("D_rel_ready", bus.core_ready, 4'b0001);
        tick();
        chk("D_rel_idx", bus.out_index, 0);
        chk("D_rel_rays", rays_issued, 1);
        chk("D_rel_ov", bus.out_valid, 1);
        wait_done(40);
        chk("D_rays", rays_issued, 4);
        chk("D_grants", pack_gr(), 64'h3012);

        // zero-sized frame
        clear_logs();
        do_start(0, 7);
        chk("E_fd", frame_done, 1);
        chk("E_busy", busy, 0);
        chk("E_en", bus.core_en, 0);
        tick();
        chk("E_fd_after", frame_done, 0);
        chk("E_busy_after", busy, 0);
        chk("E_rays", rays_issued, 0);
        chk("E_grants", gr.size(), 0);

        // 3x3 with a stray start during RUN
        clear_logs();
        bus.core_valid = 4'hF; bus.out_ready = 1'b1;
        do_start(3, 3);
        tick(); tick(); tick();
        start = 1'b1; iw = 13'd5; ih = 13'd5;
        tick();
        start = 1'b0;
        chk("F_busy", busy, 1);
        wait_done(40);
        chk("F_rays", rays_issued, 9);
        chk("F_nxfer", got.size(), 9);
        for (int k = 0; k < 9; k++)
            chk("F_idx", (k < got.size()) ? got[k] : '1, 64'(exp_f[k]));
        chk("F_fd_cnt", fd_cnt, 1);
        chk("F_grants", pack_gr(), 64'h301230123);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
